// File: rtl/sa3_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : sa3_scheduler
// Description : Round-robin scheduler sharing one 3x3 systolic array between
//               two requesters. It holds the array active for a full pass,
//               captures the four results and runs a watchdog that aborts a
//               hung pass and raises a sticky error.
// Revision    : 1.0 - initial release
// ============================================================================
module sa3_scheduler #(
  parameter int TIMEOUT_CYCLES = 24,
  parameter int CNT_W          = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       sel,
  output logic       active_sa3,
  output logic       sa_rst,
  input  logic       done_sa3,
  input  logic [7:0] c11,
  input  logic [7:0] c12,
  input  logic [7:0] c21,
  input  logic [7:0] c22,
  output logic [7:0] res_c11,
  output logic [7:0] res_c12,
  output logic [7:0] res_c21,
  output logic [7:0] res_c22,
  output logic       res_valid0,
  output logic       res_valid1,
  output logic       busy,
  output logic       err,
  input  logic       err_clr
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2,
    ST_ABORT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_last;
  logic             w_win;

  // Winner: the sole requester, or on a tie the one not granted last time.
  assign w_win = (req0 & req1) ? ~r_last : req1;

  // Scheduler FSM with all outputs registered; sel doubles as the job owner.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_last     <= 1'b1;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      sel        <= 1'b0;
      active_sa3 <= 1'b0;
      sa_rst     <= 1'b0;
      res_c11    <= 8'd0;
      res_c12    <= 8'd0;
      res_c21    <= 8'd0;
      res_c22    <= 8'd0;
      res_valid0 <= 1'b0;
      res_valid1 <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      // Clearing is the default; the ABORT branch below overrides it so that
      // a simultaneous set wins.
      if (err_clr) begin
        err <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (req0 | req1) begin
            r_state    <= ST_RUN;
            gnt0       <= ~w_win;
            gnt1       <= w_win;
            sel        <= w_win;
            active_sa3 <= 1'b1;
            busy       <= 1'b1;
            r_cnt      <= c_one;
            r_last     <= w_win;
          end
        end
        ST_RUN: begin
          if (done_sa3) begin
            r_state    <= ST_DONE;
            res_c11    <= c11;
            res_c12    <= c12;
            res_c21    <= c21;
            res_c22    <= c22;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            active_sa3 <= 1'b0;
            res_valid0 <= ~sel;
            res_valid1 <= sel;
          end else if (r_cnt == c_timeout) begin
            r_state    <= ST_ABORT;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            active_sa3 <= 1'b0;
            sa_rst     <= 1'b1;
          end else begin
            r_cnt <= r_cnt + c_one;
          end
        end
        ST_DONE: begin
          r_state    <= ST_IDLE;
          res_valid0 <= 1'b0;
          res_valid1 <= 1'b0;
          busy       <= 1'b0;
          r_cnt      <= '0;
        end
        ST_ABORT: begin
          r_state <= ST_IDLE;
          sa_rst  <= 1'b0;
          err     <= 1'b1;
          busy    <= 1'b0;
          r_cnt   <= '0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sa3_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_sa3_scheduler
// Description : Self-checking bench for sa3_scheduler. A small array model
//               raises done 17 cycles into a pass (or never, when hung), and a
//               job-timeline reference model predicts every output per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sa3_scheduler;

  localparam int TO   = 24;
  localparam int PASS = 17;

  logic       clk;
  logic       rst;
  logic       req0, req1;
  logic       gnt0, gnt1, sel, active_sa3, sa_rst;
  logic       done_sa3;
  logic [7:0] c11, c12, c21, c22;
  logic [7:0] res_c11, res_c12, res_c21, res_c22;
  logic       res_valid0, res_valid1, busy, err, err_clr;

  // Array stand-in controls.
  logic       hang;
  logic       spur;
  int         act_cnt;

  int total;
  int bad;

  // Reference model: a job is described by its offset from the grant edge.
  int          m_off;
  logic        m_w, m_last, m_sel, m_hang_job, m_err;
  logic [31:0] m_res;

  sa3_scheduler #(
    .TIMEOUT_CYCLES(TO),
    .CNT_W         (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .req1      (req1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .sel       (sel),
    .active_sa3(active_sa3),
    .sa_rst    (sa_rst),
    .done_sa3  (done_sa3),
    .c11       (c11),
    .c12       (c12),
    .c21       (c21),
    .c22       (c22),
    .res_c11   (res_c11),
    .res_c12   (res_c12),
    .res_c21   (res_c21),
    .res_c22   (res_c22),
    .res_valid0(res_valid0),
    .res_valid1(res_valid1),
    .busy      (busy),
    .err       (err),
    .err_clr   (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Array stand-in: counts its internal state S0..S16 while active.
  always @(posedge clk) begin
    if (rst || sa_rst || !active_sa3) act_cnt <= 0;
    else                              act_cnt <= act_cnt + 1;
  end

  assign done_sa3 = (active_sa3 && act_cnt == PASS - 1 && !hang) || spur;

  // Advance the reference model by one clock given this cycle's inputs.
  task automatic model_step(input logic r0, input logic r1, input logic clr, input logic rs);
    int   run_len;
    logic nerr;
    if (rs) begin
      m_off = 0; m_last = 1'b1; m_sel = 1'b0; m_err = 1'b0;
      m_res = '0; m_w = 1'b0; m_hang_job = 1'b0;
    end else begin
      run_len = m_hang_job ? TO : PASS;
      nerr    = m_err & ~clr;
      if (m_off == 0) begin
        if (r0 | r1) begin
          m_w        = (r0 & r1) ? ~m_last : r1;
          m_last     = m_w;
          m_sel      = m_w;
          m_off      = 1;
          m_hang_job = hang;
        end
      end else if (m_off < run_len) begin
        m_off++;
      end else if (m_off == run_len) begin
        m_off++;
        if (!m_hang_job) m_res = {c11, c12, c21, c22};
      end else begin
        if (m_hang_job) nerr = 1'b1;
        m_off = 0;
      end
      m_err = nerr;
    end
  endtask

  // Compare every DUT output against the model.
  task automatic check_outputs(input string tag);
    int          run_len;
    logic        run, fin;
    logic [8:0]  obs_ctl, exp_ctl;
    logic [31:0] obs_res;
    run_len = m_hang_job ? TO : PASS;
    run     = (m_off >= 1) && (m_off <= run_len);
    fin     = (m_off == run_len + 1);
    exp_ctl = {run && !m_w, run && m_w, m_sel, run, fin && m_hang_job,
               fin && !m_hang_job && !m_w, fin && !m_hang_job && m_w,
               m_off != 0, m_err};
    obs_ctl = {gnt0, gnt1, sel, active_sa3, sa_rst, res_valid0, res_valid1, busy, err};
    obs_res = {res_c11, res_c12, res_c21, res_c22};
    total++;
    assert (obs_ctl === exp_ctl) else begin
      bad++;
      $error("FAIL %s ctl{g0,g1,sel,act,sarst,rv0,rv1,busy,err} t=%0t observed=%b expected=%b",
             tag, $time, obs_ctl, exp_ctl);
    end
    total++;
    assert (obs_res === m_res) else begin
      bad++;
      $error("FAIL %s res t=%0t observed=%h expected=%h", tag, $time, obs_res, m_res);
    end
  endtask

  // One clock: drive inputs, step the model, clock, then check.
  task automatic tick(input logic r0, input logic r1, input logic clr, input logic rs,
                      input string tag);
    req0    = r0;
    req1    = r1;
    err_clr = clr;
    rst     = rs;
    c11 = 8'($urandom); c12 = 8'($urandom);
    c21 = 8'($urandom); c22 = 8'($urandom);
    model_step(r0, r1, clr, rs);
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    logic raised;
    logic got;
    total = 0; bad = 0;
    hang = 1'b0; spur = 1'b0;
    req0 = 1'b0; req1 = 1'b0; err_clr = 1'b0; rst = 1'b1;
    c11 = 8'd0; c12 = 8'd0; c21 = 8'd0; c22 = 8'd0;

    // Reset state.
    tick(0, 0, 0, 1, "reset");
    tick(0, 0, 0, 1, "reset");
    tick(0, 0, 0, 0, "idle");

    // Single request from requester 0, released after one cycle.
    tick(1, 0, 0, 0, "single");
    for (int i = 0; i < 25; i++) tick(0, 0, 0, 0, "single");

    // Contention: both held, grants alternate.
    for (int i = 0; i < 80; i++) tick(1, 1, 0, 0, "contend");
    for (int i = 0; i < 30; i++) tick(0, 0, 0, 0, "drain");

    // Withdrawal mid-run, then a new request raised during DONE.
    for (int i = 0; i < 5; i++) tick(0, 1, 0, 0, "withdraw");
    raised = 1'b0;
    for (int i = 0; i < 45; i++) begin
      if (m_off == PASS + 1) raised = 1'b1;
      tick(raised, 0, 0, 0, "withdraw");
    end
    for (int i = 0; i < 30; i++) tick(0, 0, 0, 0, "drain");

    // Timeout with the array hung, then clear.
    hang = 1'b1;
    tick(1, 0, 0, 0, "timeout");
    for (int i = 0; i < 30; i++) tick(0, 0, 0, 0, "timeout");
    tick(0, 0, 1, 0, "err_clr");
    tick(0, 0, 0, 0, "err_clr");

    // Timeout with err_clr landing exactly in the ABORT cycle.
    tick(0, 1, 0, 0, "abort_clr");
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (m_off == TO + 1) got = 1'b1;
      tick(0, 0, m_off == TO + 1, 0, "abort_clr");
    end
    total++;
    assert (got === 1'b1) else begin
      bad++;
      $error("FAIL abort_reached observed=%b expected=1", got);
    end
    hang = 1'b0;
    tick(0, 0, 1, 0, "err_clr2");
    tick(0, 0, 0, 0, "err_clr2");

    // Spurious done while idle must be ignored.
    spur = 1'b1;
    tick(0, 0, 0, 0, "spur_idle");
    spur = 1'b0;
    tick(0, 0, 0, 0, "spur_idle");

    // Reset at RUN cycle 8, then a fresh tie goes to requester 0.
    tick(1, 1, 0, 0, "midrst");
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      if (m_off == 8) got = 1'b1;
      else            tick(1, 1, 0, 0, "midrst");
    end
    total++;
    assert (got === 1'b1) else begin
      bad++;
      $error("FAIL run8_reached observed=%b expected=1", got);
    end
    tick(1, 1, 0, 1, "midrst_rst");
    for (int i = 0; i < 45; i++) tick(1, 1, 0, 0, "after_rst");
    for (int i = 0; i < 30; i++) tick(0, 0, 0, 0, "drain");

    // Randomized traffic.
    for (int i = 0; i < 700; i++) begin
      if (m_off == 0) begin
        hang = ($urandom_range(0, 7) == 0);
        spur = ($urandom_range(0, 3) == 0);
      end else begin
        spur = 1'b0;
      end
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 149) == 0), "random");
    end
    spur = 1'b0;
    hang = 1'b0;
    for (int i = 0; i < 30; i++) tick(0, 0, 0, 0, "final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
